axi_lite_ctrl_regs: RTL and testbench

AXI_LITE_CTRL_REGS -- requirements
Module: axi_lite_ctrl_regs

---
 rtl/axi_lite_pkg.sv | 29 ++
 rtl/axi_lite_ctrl_regs_if.sv | 48 ++++
 rtl/axi_lite_ctrl_regs.sv | 165 ++++++++++++++++
 tb/tb_axi_lite_ctrl_regs.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// AXI4-Lite response codes and the byte-lane merge shared by register files
// that sit on an AXI4-Lite slave port.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // Widest supported data bus; narrower callers zero-extend and truncate.
  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_data,
    input logic [MAX_DATA_WIDTH-1:0] new_data,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_data;
    for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_ctrl_regs_if.sv
// AXI4-Lite bus bundle (five channels) with master and slave views.
interface axi_lite_ctrl_regs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );

endinterface

// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control/status register file: RW control registers at the low
// indices (register 0 may carry self-clearing pulse bits), RO status above.
module axi_lite_ctrl_regs
  import axi_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    NUM_REGS   = 8,
  parameter int                    NUM_RO     = 2,
  parameter logic [DATA_WIDTH-1:0] PULSE_MASK = 32'h2
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  axi_lite_ctrl_regs_if.slave                      s_axi,
  output logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0]  ctrl_regs,
  input  logic [NUM_RO*DATA_WIDTH-1:0]             status_in,
  output logic [NUM_REGS-NUM_RO-1:0]               wr_strobe
);

  localparam int NUM_RW     = NUM_REGS - NUM_RO;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(NUM_REGS);

  if (NUM_RO < 1 || NUM_RO >= NUM_REGS ||
      NUM_REGS > (1 << (ADDR_WIDTH - ADDR_LSB)) ||
      (DATA_WIDTH != 32 && DATA_WIDTH != 64)) begin : g_param_check
    $error("axi_lite_ctrl_regs: illegal parameter combination");
  end

  // Address decode: any address bit above the index field is out of range,
  // as is an index beyond NUM_REGS when NUM_REGS is not a power of two.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_LSB +: IDX_W];
  endfunction

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ((addr >> (ADDR_LSB + IDX_W)) == '0) && (int'(addr_idx(addr)) < NUM_REGS);
  endfunction

  // ---------------- write path state ----------------
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  bvalid_q;
  axi_resp_e             bresp_q;
  logic [DATA_WIDTH-1:0] rw_q [NUM_RW];

  // ---------------- read path state ----------------
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  axi_resp_e             rresp_q;
  logic [DATA_WIDTH-1:0] rd_data;
  axi_resp_e             rd_resp;

  logic aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [IDX_W-1:0] wr_idx, ar_idx;

  assign s_axi.awready = ~aw_held & ~bvalid_q;
  assign s_axi.wready  = ~w_held & ~bvalid_q;
  assign s_axi.arready = ~rvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign aw_hs  = s_axi.awvalid & s_axi.awready;
  assign w_hs   = s_axi.wvalid & s_axi.wready;
  assign ar_hs  = s_axi.arvalid & s_axi.arready;
  assign commit = aw_held & w_held;

  assign wr_idx = addr_idx(aw_addr_q);
  assign wr_ok  = addr_in_range(aw_addr_q) && (int'(wr_idx) < NUM_RW);
  assign ar_idx = addr_idx(s_axi.araddr);

  // Protection attributes carry no meaning for this register file.
  logic unused_prot;
  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  // NOTE: the capture registers have no reset; they are only consumed while
  // their held flag is set, and the flags themselves are reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_hs) aw_addr_q <= s_axi.awaddr;
    if (w_hs) begin
      w_data_q <= s_axi.wdata;
      w_strb_q <= s_axi.wstrb;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; later assignments in the block take priority.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_strobe <= '0;
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
    end else begin
      wr_strobe <= '0;
      rw_q[0]   <= rw_q[0] & ~PULSE_MASK;

      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
      if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;

      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_RW; i++) begin
          if (wr_ok && wr_idx == IDX_W'(i)) begin
            rw_q[i]      <= DATA_WIDTH'(strb_merge(MAX_DATA_WIDTH'(rw_q[i]),
                                                   MAX_DATA_WIDTH'(w_data_q),
                                                   MAX_STRB_WIDTH'(w_strb_q)));
            wr_strobe[i] <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    ctrl_regs = '0;
    for (int i = 0; i < NUM_RW; i++) ctrl_regs[i*DATA_WIDTH +: DATA_WIDTH] = rw_q[i];
  end

  // Read mux: reads the registered RW value, so a same-edge write commit
  // is not yet visible and the pre-write value is returned.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (addr_in_range(s_axi.araddr)) begin
      rd_resp = RESP_OKAY;
      for (int i = 0; i < NUM_RW; i++) begin
        if (ar_idx == IDX_W'(i)) rd_data = rw_q[i];
      end
      for (int j = 0; j < NUM_RO; j++) begin
        if (ar_idx == IDX_W'(NUM_RW + j)) rd_data = status_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Bench for axi_lite_ctrl_regs: table of directed transactions, hand-built
// timing sequences, and random traffic against a byte-address register model.
module tb_axi_lite_ctrl_regs;
  import axi_lite_pkg::*;

  localparam int          DW    = 32;
  localparam int          AW    = 6;
  localparam int          NREG  = 8;
  localparam int          NRO   = 2;
  localparam int          NRW   = NREG - NRO;
  localparam logic [31:0] PMASK = 32'h2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NRW*DW-1:0] ctrl_regs;
  logic [NRO*DW-1:0] status_in;
  logic [NRW-1:0]    wr_strobe;

  axi_lite_ctrl_regs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_lite_ctrl_regs #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NREG), .NUM_RO(NRO), .PULSE_MASK(PMASK)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus),
    .ctrl_regs    (ctrl_regs),
    .status_in    (status_in),
    .wr_strobe    (wr_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_rw     [NRW];
  logic [31:0] m_status [NRO];
  int n_cmp = 0;
  int n_err = 0;

  assign status_in = {m_status[1], m_status[0]};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NRW*DW-1:0] model_ctrl();
    logic [NRW*DW-1:0] v;
    for (int i = 0; i < NRW; i++) v[i*DW +: DW] = m_rw[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NRW; i++) m_rw[i] = '0;
  endfunction

  // Byte address -> register number; registers past NREG*4 do not exist.
  function automatic logic [1:0] model_write(input logic [AW-1:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb, output logic [NRW-1:0] strobe);
    int reg_no;
    reg_no = int'(addr) / 4;
    strobe = '0;
    if (int'(addr) >= NREG * 4 || reg_no >= NRW) return RESP_SLVERR;
    for (int b = 0; b < 4; b++) if (strb[b]) m_rw[reg_no][8*b +: 8] = data[8*b +: 8];
    strobe[reg_no] = 1'b1;
    return RESP_OKAY;
  endfunction

  function automatic void model_read(input logic [AW-1:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int reg_no;
    reg_no = int'(addr) / 4;
    if (int'(addr) >= NREG * 4) begin
      data = '0; resp = RESP_SLVERR;
    end else if (reg_no < NRW) begin
      data = m_rw[reg_no]; resp = RESP_OKAY;
    end else begin
      data = m_status[reg_no - NRW]; resp = RESP_OKAY;
    end
  endfunction

  // ---------------- bus tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic [NRW-1:0] exp_strobe;
    logic [1:0]     exp_resp;
    logic           aw_go, w_go;
    int             n;
    exp_resp    = model_write(addr, data, strb, exp_strobe);
    bus.awaddr  = addr;
    bus.awprot  = 3'($urandom);
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 20) begin
      aw_go = bus.awvalid & bus.awready;
      w_go  = bus.wvalid & bus.wready;
      tick();
      n++;
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go)  bus.wvalid  = 1'b0;
    end
    check("wr_accept_pending", {bus.awvalid, bus.wvalid}, 2'b00);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin
      tick();
      n++;
    end
    check("wr_bvalid_latency", n, 1);
    check("wr_bresp", bus.bresp, exp_resp);
    check("wr_strobe_at_commit", wr_strobe, exp_strobe);
    check("wr_ctrl_at_commit", ctrl_regs, model_ctrl());
    resp = bus.bresp;
    m_rw[0] = m_rw[0] & ~PMASK;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("wr_bvalid_clear", bus.bvalid, 1'b0);
    check("wr_strobe_clear", wr_strobe, '0);
    check("wr_ctrl_after", ctrl_regs, model_ctrl());
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.araddr  = addr;
    bus.arprot  = 3'($urandom);
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.arvalid = 1'b0;
    check("rd_rvalid", bus.rvalid, 1'b1);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("rd_rvalid_clear", bus.rvalid, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        is_read;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0]    d, ed, old_val, new_val;
    logic [1:0]     r, er;
    logic [NRW-1:0] es;
    logic [5:0]     a;

    vecs[0]  = '{"w_reg2_full",    1'b0, 6'h08, 32'h11223344, 4'hF, 32'h0,        RESP_OKAY};
    vecs[1]  = '{"w_reg2_byte1",   1'b0, 6'h08, 32'h0000FF00, 4'h2, 32'h0,        RESP_OKAY};
    vecs[2]  = '{"r_reg2_merged",  1'b1, 6'h08, 32'h0,        4'h0, 32'h1122FF44, RESP_OKAY};
    vecs[3]  = '{"w_ro_reg6",      1'b0, 6'h18, 32'hFFFFFFFF, 4'hF, 32'h0,        RESP_SLVERR};
    vecs[4]  = '{"w_oor_3c",       1'b0, 6'h3C, 32'hFFFFFFFF, 4'hF, 32'h0,        RESP_SLVERR};
    vecs[5]  = '{"r_status1",      1'b1, 6'h1C, 32'h0,        4'h0, 32'hDEADBEEF, RESP_OKAY};
    vecs[6]  = '{"r_oor_3c",       1'b1, 6'h3C, 32'h0,        4'h0, 32'h0,        RESP_SLVERR};
    vecs[7]  = '{"w_reg3_nostrb",  1'b0, 6'h0C, 32'hFFFFFFFF, 4'h0, 32'h0,        RESP_OKAY};
    vecs[8]  = '{"r_reg3_intact",  1'b1, 6'h0C, 32'h0,        4'h0, 32'h0,        RESP_OKAY};
    vecs[9]  = '{"r_status0",      1'b1, 6'h18, 32'h0,        4'h0, 32'h12345678, RESP_OKAY};
    vecs[10] = '{"r_oor_20",       1'b1, 6'h20, 32'h0,        4'h0, 32'h0,        RESP_SLVERR};
    vecs[11] = '{"w_reg5_last_rw", 1'b0, 6'h14, 32'hCAFEF00D, 4'hF, 32'h0,        RESP_OKAY};
    vecs[12] = '{"r_reg5_unalign", 1'b1, 6'h16, 32'h0,        4'h0, 32'hCAFEF00D, RESP_OKAY};
    vecs[13] = '{"r_reg2_no_ro_w", 1'b1, 6'h08, 32'h0,        4'h0, 32'h1122FF44, RESP_OKAY};

    model_reset();
    m_status[0] = 32'h12345678;
    m_status[1] = 32'hDEADBEEF;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_wr_strobe", wr_strobe, '0);
    check("rst_ctrl_regs", ctrl_regs, '0);
    #2 rst = 1'b0;
    tick();
    check("rst_ready_first_cycle", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // Table-driven transactions
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_read) begin
        axi_read(vecs[i].addr, d, r);
        check({vecs[i].name, "_rdata"}, d, vecs[i].exp_rdata);
        check({vecs[i].name, "_rresp"}, r, vecs[i].exp_resp);
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        check({vecs[i].name, "_bresp"}, r, vecs[i].exp_resp);
      end
    end

    // AW first, W three cycles later
    er = model_write(6'h04, 32'hA5A5A5A5, 4'hF, es);
    bus.awaddr  = 6'h04;
    bus.awvalid = 1'b1;
    check("seq_awready_idle", bus.awready, 1'b1);
    tick();
    bus.awvalid = 1'b0;
    check("seq_aw_held_ready", {bus.awready, bus.wready}, 2'b01);
    tick();
    tick();
    check("seq_no_commit_without_w", bus.bvalid, 1'b0);
    bus.wdata  = 32'hA5A5A5A5;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("seq_bvalid_not_yet", bus.bvalid, 1'b0);
    tick();
    check("seq_bvalid_rise", bus.bvalid, 1'b1);
    check("seq_bresp", bus.bresp, er);
    check("seq_wr_strobe", wr_strobe, es);
    check("seq_ctrl", ctrl_regs, model_ctrl());
    m_rw[0] = m_rw[0] & ~PMASK;
    tick();
    check("seq_bvalid_hold", {bus.bvalid, bus.bresp}, {1'b1, er});
    check("seq_strobe_one_cycle", wr_strobe, '0);
    check("seq_ready_blocked", {bus.awready, bus.wready}, 2'b00);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("seq_bvalid_done", {bus.bvalid, bus.awready, bus.wready}, 3'b011);

    // Self-clearing bit in register 0
    axi_write(6'h00, 32'h3, 4'hF, r);
    check("pulse_bresp", r, RESP_OKAY);
    axi_read(6'h00, d, r);
    check("pulse_readback", d, 32'h1);

    // Read and write commit on the same edge to the same register
    axi_write(6'h10, 32'h0BADC0DE, 4'hF, r);
    model_read(6'h10, old_val, er);
    new_val = 32'h600DF00D;
    er = model_write(6'h10, new_val, 4'hF, es);
    bus.awaddr = 6'h10; bus.awvalid = 1'b1;
    bus.wdata  = new_val; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.araddr  = 6'h10;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("rw_same_edge_rvalid", {bus.rvalid, bus.bvalid}, 2'b11);
    check("rw_same_edge_rdata_old", bus.rdata, old_val);
    check("rw_same_edge_ctrl_new", ctrl_regs, model_ctrl());
    m_rw[0] = m_rw[0] & ~PMASK;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    check("rw_same_edge_done", {bus.rvalid, bus.bvalid}, 2'b00);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      a = 6'($urandom_range(0, 43));
      if ($urandom_range(0, 1) == 1) begin
        d  = $urandom;
        axi_write(a, d, 4'($urandom_range(0, 15)), r);
      end else begin
        m_status[$urandom_range(0, 1)] = $urandom;
        model_read(a, ed, er);
        axi_read(a, d, r);
        check("rand_rdata", d, ed);
        check("rand_rresp", r, er);
      end
    end

    // Reset while a write response is pending with BREADY low
    er = model_write(6'h04, 32'h5555AAAA, 4'hF, es);
    bus.awaddr = 6'h04; bus.awvalid = 1'b1;
    bus.wdata  = 32'h5555AAAA; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    tick();
    check("abort_bvalid_pending", bus.bvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("abort_bvalid_cleared", bus.bvalid, 1'b0);
    check("abort_ctrl_cleared", ctrl_regs, '0);
    check("abort_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("abort_ready_after", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // Reset while only the address is held
    bus.awaddr = 6'h08; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("abort_aw_held", bus.awready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("abort_aw_held_cleared", {bus.awready, bus.bvalid}, 2'b10);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // W alone must wait for a fresh address, then complete normally
    bus.wdata = 32'h00C0FFEE; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    tick();
    tick();
    check("w_only_no_commit", {bus.bvalid, bus.wready}, 2'b00);
    check("w_only_ctrl", ctrl_regs, '0);
    er = model_write(6'h08, 32'h00C0FFEE, 4'hF, es);
    bus.awaddr = 6'h08; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("w_first_not_yet", bus.bvalid, 1'b0);
    tick();
    check("w_first_commit", {bus.bvalid, bus.bresp, wr_strobe}, {1'b1, er, es});
    check("w_first_ctrl", ctrl_regs, model_ctrl());
    m_rw[0] = m_rw[0] & ~PMASK;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    axi_write(6'h04, 32'h13579BDF, 4'hF, r);
    check("post_reset_write_bresp", r, RESP_OKAY);
    axi_read(6'h04, d, r);
    check("post_reset_read", {d, r}, {32'h13579BDF, 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
